etpu_wb_host: RTL
=================

Name: etpu_wb_host

Overview:
- Wishbone classic initiator (master) that drives the edu TPU Wishbone responder from the host side.
- A local producer pushes one job into an internal word buffer: 3 weight words, then 6 input words.
- On start the block issues 9 single write cycles to the TPU base address, waits a fixed compute interval, then issues 5 single read cycles.
- Each returned result word is presented on a valid/ready output port.
- Used as the on-chip stimulus/DMA engine in place of the management core.

Parameters:
- BASE_ADDRESS, 32'h3000_0000, Wishbone address for every cycle.
- N_WEIGHT, 3, weight words written first.
- N_INPUT, 6, input words written after the weights.
- N_RESULT, 5, result words read back; the last word carries valid data in bits [15:0] only.
- COMPUTE_WAIT, 64, clk cycles idle between the last write ack and the first read request (1..255).
- TIMEOUT, 255, max cycles waiting for ack (used only with the optional feature).

Ports:
- caravel_wb_clk_i  in  1  sole clock, all logic on rising edge
- caravel_wb_rst_n_i  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, launch job
- busy  out  1  high from accepted start until DONE or ERR exit
- done  out  1  one-cycle pulse after last result handed off
- err  out  1  sticky timeout flag, cleared by next accepted start
- load_valid  in  1  buffer push request
- load_ready  out  1  buffer can accept (IDLE and count < N_WEIGHT+N_INPUT)
- load_data  in  32  word to buffer
- res_valid  out  1  result word available
- res_ready  in  1  consumer accepts result
- res_data  out  32  result word (read word N_RESULT-1 zero-extended from [15:0])
- res_last  out  1  high with final result word
- caravel_wb_cyc_o  out  1  bus cycle
- caravel_wb_stb_o  out  1  strobe
- caravel_wb_we_o  out  1  write enable
- caravel_wb_sel_o  out  4  byte select, always 4'hF while stb is high
- caravel_wb_adr_o  out  32  address, BASE_ADDRESS while stb is high
- caravel_wb_dat_o  out  32  write data
- caravel_wb_dat_i  in  32  read data
- caravel_wb_ack_i  in  1  acknowledge

Behaviour:
- Reset (async assert, sync deassert) clears state to IDLE and empties the buffer.
- Outputs at reset: cyc/stb/we=0, sel=0, adr=0, dat_o=0, busy=0, done=0, err=0, res_valid=0, res_last=0, res_data=0, load_ready=0 until the first clock after deassertion.
- Reset asserted mid-cycle drops cyc/stb immediately; no cycle completion is attempted.
- Buffer: 9x32 FIFO, filled in IDLE only. A push occurs when load_valid && load_ready. The word count saturates at 9; pushes while full are not accepted.
- Start is accepted only in IDLE with count==9. Start otherwise is ignored: no state change, err unchanged.
- States:
  - IDLE: accept pushes; on accepted start go to WR_REQ with index=0.
  - WR_REQ: cyc=stb=we=1, dat_o=buffer[index]. All bus outputs are held stable until ack is sampled. On the ack edge, index++ and go to WR_GAP.
  - WR_GAP: cyc=stb=0 for exactly one cycle. If index==9, go to WAIT and load the counter with COMPUTE_WAIT; otherwise go to WR_REQ.
  - WAIT: decrement the counter; at 0 go to RD_REQ with rindex=0. The bus is idle throughout.
  - RD_REQ: entered only when res_valid==0 or a res handoff happens in the same cycle; otherwise stall with stb low. Drive cyc=stb=1, we=0. On ack, capture dat_i into res_data (masked to [15:0] when rindex==N_RESULT-1), set res_valid=1, set res_last=(rindex==N_RESULT-1), rindex++, go to RD_GAP.
  - RD_GAP: one idle cycle; then go to RD_REQ if rindex<N_RESULT, else DONE.
  - DONE: wait for the final handoff; pulse done, clear busy, empty the buffer, go to IDLE.
- Latencies:
  - Accepted start -> stb high on the next cycle.
  - ack -> stb low on the next cycle.
  - Minimum write phase with ack returned 1 cycle after stb: 9*3=27 cycles.
- res_valid falls on the handoff (res_valid && res_ready) unless a new word is captured on the same edge.
- ack sampled while stb is low is ignored.
- dat_i is sampled only on the ack edge during a read.

Optional Feature:
- Macro ETPU_WB_TIMEOUT_EN.
- Defined:
  - A counter runs while in WR_REQ or RD_REQ with stb high.
  - When TIMEOUT cycles elapse without ack: drop cyc/stb next cycle, set err=1, empty the buffer, clear busy, go to IDLE. No done pulse.
  - Any unhandled res word is discarded (res_valid=0).
- Undefined: no counter; the master waits for ack indefinitely; err stays 0.

Test Plan:
- Push 9 words 0x11..0x19, start, responder acks 1 cycle after stb -> 9 write cycles in order with dat_o 0x11..0x19, sel=F, adr=0x3000_0000, one idle cycle between each; stb low for exactly 64 cycles; 5 reads.
- Responder returns 0xA1A2A3A4 on reads 0-3 and 0xDEADBEEF on read 4 -> res_data 0xA1A2A3A4 x4, then 0x0000BEEF with res_last=1; done pulses once after the last handoff.
- Hold res_ready=0 after the first result -> no further stb until res_ready=1; no result lost or duplicated.
- Start with 8 words buffered, and start while busy -> ignored; bus stays idle, busy unchanged; load_ready=0 after 9 pushes.
- Assert reset while stb is high in write index 4 -> cyc/stb low asynchronously; after release, state is IDLE, buffer empty, all outputs at reset values.
- ETPU_WB_TIMEOUT_EN, responder never acks -> stb drops 256 cycles after it rose, err=1, busy=0; the next valid start clears err.

Source files
------------

// File: rtl/etpu_wb_host.sv
// Wishbone classic host for the edu TPU: streams a buffered 9-word job out, waits, reads 5 results back.
// Optional ETPU_WB_TIMEOUT_EN aborts a bus cycle that goes TIMEOUT cycles without ack.
module etpu_wb_host #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          N_WEIGHT     = 3,
    parameter int          N_INPUT      = 6,
    parameter int          N_RESULT     = 5,
    parameter int          COMPUTE_WAIT = 64
`ifdef ETPU_WB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT      = 255
`endif
) (
    input  logic        caravel_wb_clk_i,
    input  logic        caravel_wb_rst_n_i,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_last,
    output logic        caravel_wb_cyc_o,
    output logic        caravel_wb_stb_o,
    output logic        caravel_wb_we_o,
    output logic [3:0]  caravel_wb_sel_o,
    output logic [31:0] caravel_wb_adr_o,
    output logic [31:0] caravel_wb_dat_o,
    input  logic [31:0] caravel_wb_dat_i,
    input  logic        caravel_wb_ack_i
);

    localparam int NW = N_WEIGHT + N_INPUT;
    localparam int CW = $clog2(NW + 1);
    localparam int RW = $clog2(N_RESULT + 1);
    localparam logic [CW-1:0] NW_C      = CW'(NW);
    localparam logic [RW-1:0] NR_C      = RW'(N_RESULT);
    localparam logic [RW-1:0] LAST_C    = RW'(N_RESULT - 1);
    // WR_GAP already supplies one idle cycle, so WAIT covers the rest.
    localparam logic [7:0]    WAIT_INIT = 8'(COMPUTE_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_GAP, S_WAIT, S_RD_REQ, S_RD_GAP, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, index;
    logic [RW-1:0] rindex;
    logic [7:0]    wait_cnt;
    logic          armed;
    logic [31:0]   buf_q [NW];
    logic          push, start_ok, res_free, bus_act, tmo_hit;

    assign bus_act  = (state == S_WR_REQ) || (state == S_RD_REQ);
    assign push     = load_valid && load_ready;
    assign start_ok = start && (state == S_IDLE) && (count == NW_C);
    assign res_free = !res_valid || res_ready;

`ifdef ETPU_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
        if (!caravel_wb_rst_n_i)                tmo_cnt <= '0;
        else if (bus_act && !caravel_wb_ack_i)  tmo_cnt <= tmo_cnt + TW'(1);
        else                                    tmo_cnt <= '0;
    end

    assign tmo_hit = bus_act && !caravel_wb_ack_i && (tmo_cnt == TMO_C);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
        if (!caravel_wb_rst_n_i) state <= S_IDLE;
        else                     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_ok) state_nx = S_WR_REQ;
            S_WR_REQ: if (caravel_wb_ack_i) state_nx = S_WR_GAP;
            S_WR_GAP: begin
                if (index == NW_C) state_nx = (WAIT_INIT == 8'd0) ? S_RD_REQ : S_WAIT;
                else               state_nx = S_WR_REQ;
            end
            S_WAIT:   if (wait_cnt == 8'd1) state_nx = S_RD_REQ;
            S_RD_REQ: if (caravel_wb_ack_i) state_nx = S_RD_GAP;
            // Next read only once the previous word is gone (or leaves this edge).
            S_RD_GAP: begin
                if (rindex == NR_C) state_nx = S_DONE;
                else if (res_free)  state_nx = S_RD_REQ;
            end
            S_DONE:   if (res_free) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (tmo_hit) state_nx = S_IDLE;
    end

    // Buffer storage carries no reset; validity is tracked by count.
    always_ff @(posedge caravel_wb_clk_i) begin
        if (push) buf_q[count] <= load_data;
    end

    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
        if (!caravel_wb_rst_n_i) begin
            armed     <= 1'b0;
            count     <= '0;
            index     <= '0;
            rindex    <= '0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
        end else begin
            armed <= 1'b1;
            done  <= 1'b0;
            if (push) count <= count + CW'(1);
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
                res_last  <= 1'b0;
            end
            case (state)
                S_IDLE: if (start_ok) begin
                    index  <= '0;
                    rindex <= '0;
                    err    <= 1'b0;
                end
                S_WR_REQ: if (caravel_wb_ack_i) index <= index + CW'(1);
                S_WR_GAP: if (index == NW_C) wait_cnt <= WAIT_INIT;
                S_WAIT:   wait_cnt <= wait_cnt - 8'd1;
                S_RD_REQ: if (caravel_wb_ack_i) begin
                    res_data  <= (rindex == LAST_C) ? {16'h0000, caravel_wb_dat_i[15:0]}
                                                    : caravel_wb_dat_i;
                    res_valid <= 1'b1;
                    res_last  <= (rindex == LAST_C);
                    rindex    <= rindex + RW'(1);
                end
                S_DONE: if (res_free) begin
                    done  <= 1'b1;
                    count <= '0;
                end
                default: ;
            endcase
            if (tmo_hit) begin
                err       <= 1'b1;
                count     <= '0;
                res_valid <= 1'b0;
                res_last  <= 1'b0;
            end
        end
    end

    assign busy             = (state != S_IDLE);
    assign load_ready       = armed && (state == S_IDLE) && (count != NW_C);
    assign caravel_wb_cyc_o = bus_act;
    assign caravel_wb_stb_o = bus_act;
    assign caravel_wb_we_o  = (state == S_WR_REQ);
    assign caravel_wb_sel_o = bus_act ? 4'hF : 4'h0;
    assign caravel_wb_adr_o = bus_act ? BASE_ADDRESS : 32'h0;
    assign caravel_wb_dat_o = (state == S_WR_REQ) ? buf_q[index] : 32'h0;

endmodule
